// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: data width, ALU operation
// encodings, divider FSM state encoding and small arithmetic helpers.
package exe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] XLEN_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] XLEN_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] XLEN_ONE  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] XLEN_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] EXE_OP_ADD   = 5'd0;
    localparam logic [4:0] EXE_OP_SUB   = 5'd1;
    localparam logic [4:0] EXE_OP_SLL   = 5'd2;
    localparam logic [4:0] EXE_OP_SLT   = 5'd3;
    localparam logic [4:0] EXE_OP_SLTU  = 5'd4;
    localparam logic [4:0] EXE_OP_XOR   = 5'd5;
    localparam logic [4:0] EXE_OP_SRL   = 5'd6;
    localparam logic [4:0] EXE_OP_SRA   = 5'd7;
    localparam logic [4:0] EXE_OP_OR    = 5'd8;
    localparam logic [4:0] EXE_OP_AND   = 5'd9;
    localparam logic [4:0] EXE_OP_PASS2 = 5'd10;
    localparam logic [4:0] EXE_OP_MUL   = 5'd11;
    localparam logic [4:0] EXE_OP_DIV   = 5'd12;
    localparam logic [4:0] EXE_OP_DIVU  = 5'd13;
    localparam logic [4:0] EXE_OP_REM   = 5'd14;
    localparam logic [4:0] EXE_OP_REMU  = 5'd15;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // True for the four multi-cycle divide/remainder operations.
    function automatic logic is_div_op(input logic [4:0] op);
        logic res;
        case (op)
            EXE_OP_DIV, EXE_OP_DIVU, EXE_OP_REM, EXE_OP_REMU: res = 1'b1;
            default:                                          res = 1'b0;
        endcase
        return res;
    endfunction

    // Two's-complement magnitude of a signed value (MIN maps to itself,
    // which is the correct unsigned magnitude).
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] res;
        if (v[XLEN-1]) begin
            res = ~v + XLEN_ONE;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/exe_if.sv
// ID/EX -> EX/MEM bundle. The issuing side (decode stage or bench) uses the
// master modport; the execute stage uses the slave modport.
interface exe_if;
    import exe_pkg::*;

    logic            inst_valid_i;
    logic [4:0]      alu_op_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_addr_i;
    logic            rd_we_i;
    logic            flush_i;
    logic [4:0]      rd_addr_o;
    logic [XLEN-1:0] rd_data_o;
    logic            rd_we_o;
    logic            stall_o;

    modport master (
        output inst_valid_i, alu_op_i, op1_i, op2_i, rd_addr_i, rd_we_i, flush_i,
        input  rd_addr_o, rd_data_o, rd_we_o, stall_o
    );

    modport slave (
        input  inst_valid_i, alu_op_i, op1_i, op2_i, rd_addr_i, rd_we_i, flush_i,
        output rd_addr_o, rd_data_o, rd_we_o, stall_o
    );

endinterface

// File: rtl/exe_div.sv
// Iterative restoring divider: one quotient bit per cycle over 32 cycles.
// Signed operations divide magnitudes and fix the signs at the end.
// Divide-by-zero and signed overflow skip the iteration and go straight to
// DONE with their architectural results. Only built when RV32M_DIV_EN is
// defined.
`ifdef RV32M_DIV_EN
module exe_div
    import exe_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start,
    input  logic            flush,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    div_state_e      state_r;
    logic [4:0]      cnt_r;
    logic [XLEN-1:0] q_r;
    logic [XLEN-1:0] r_r;
    logic [XLEN-1:0] dvs_r;
    logic            neg_q_r;
    logic            neg_r_r;

    logic            div_zero_s;
    logic            ovf_s;
    logic [XLEN-1:0] abs_dvd_s;
    logic [XLEN-1:0] abs_dvs_s;
    logic [XLEN:0]   shift_s;
    logic [XLEN:0]   diff_s;

    // Classify the incoming operands and form their magnitudes.
    always_comb begin
        div_zero_s = (divisor == XLEN_ZERO);
        ovf_s      = is_signed & (dividend == XLEN_MIN) & (divisor == XLEN_ONES);
        if (is_signed) begin
            abs_dvd_s = abs_val(dividend);
            abs_dvs_s = abs_val(divisor);
        end else begin
            abs_dvd_s = dividend;
            abs_dvs_s = divisor;
        end
    end

    // One restoring step: shift the next dividend bit in and trial-subtract.
    always_comb begin
        shift_s = {r_r, q_r[XLEN-1]};
        diff_s  = shift_s - {1'b0, dvs_r};
    end

    // Divider FSM: IDLE accepts, CALC iterates 32 times, DONE presents one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= DIV_IDLE;
            cnt_r   <= 5'd0;
            q_r     <= XLEN_ZERO;
            r_r     <= XLEN_ZERO;
            dvs_r   <= XLEN_ZERO;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (flush) begin
            state_r <= DIV_IDLE;
            cnt_r   <= 5'd0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start) begin
                        cnt_r <= 5'd0;
                        dvs_r <= abs_dvs_s;
                        if (div_zero_s) begin
                            q_r     <= XLEN_ONES;
                            r_r     <= dividend;
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            state_r <= DIV_DONE;
                        end else if (ovf_s) begin
                            q_r     <= XLEN_MIN;
                            r_r     <= XLEN_ZERO;
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            state_r <= DIV_DONE;
                        end else begin
                            q_r     <= abs_dvd_s;
                            r_r     <= XLEN_ZERO;
                            neg_q_r <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                            neg_r_r <= is_signed & dividend[XLEN-1];
                            state_r <= DIV_CALC;
                        end
                    end else begin
                        state_r <= DIV_IDLE;
                    end
                end
                DIV_CALC: begin
                    if (diff_s[XLEN]) begin
                        r_r <= shift_s[XLEN-1:0];
                    end else begin
                        r_r <= diff_s[XLEN-1:0];
                    end
                    q_r   <= {q_r[XLEN-2:0], ~diff_s[XLEN]};
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r <= DIV_DONE;
                    end else begin
                        state_r <= DIV_CALC;
                    end
                end
                DIV_DONE: begin
                    state_r <= DIV_IDLE;
                end
                default: begin
                    state_r <= DIV_IDLE;
                end
            endcase
        end
    end

    // Status flags and sign-corrected results.
    always_comb begin
        busy = (state_r == DIV_CALC);
        done = (state_r == DIV_DONE);
        if (neg_q_r) begin
            quotient = ~q_r + XLEN_ONE;
        end else begin
            quotient = q_r;
        end
        if (neg_r_r) begin
            remainder = ~r_r + XLEN_ONE;
        end else begin
            remainder = r_r;
        end
    end

endmodule
`endif

// File: rtl/exe.sv
// Execute stage: single-cycle ALU plus an optional iterative divider.
// Optional feature macro: RV32M_DIV_EN (divide/remainder support). Without
// it, divide ops retire in one cycle with no write and stall_o stays low.
module exe
    import exe_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    exe_if.slave bus
);

    logic [XLEN-1:0] alu_res_s;
    logic            alu_ok_s;
    logic            div_busy_s;
    logic            div_done_s;
    logic            div_we_s;
    logic [4:0]      div_addr_s;
    logic [XLEN-1:0] div_res_s;
    logic            rd_we_s;
    logic [4:0]      rd_addr_s;
    logic [XLEN-1:0] rd_data_s;
    logic            stall_s;

    // Single-cycle ALU; alu_ok_s marks op codes this path retires.
    always_comb begin
        alu_res_s = XLEN_ZERO;
        alu_ok_s  = 1'b1;
        case (bus.alu_op_i)
            EXE_OP_ADD:   alu_res_s = bus.op1_i + bus.op2_i;
            EXE_OP_SUB:   alu_res_s = bus.op1_i - bus.op2_i;
            EXE_OP_SLL:   alu_res_s = bus.op1_i << bus.op2_i[4:0];
            EXE_OP_SRL:   alu_res_s = bus.op1_i >> bus.op2_i[4:0];
            EXE_OP_SRA:   alu_res_s = $unsigned($signed(bus.op1_i) >>> bus.op2_i[4:0]);
            EXE_OP_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, ($signed(bus.op1_i) < $signed(bus.op2_i))};
            EXE_OP_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, (bus.op1_i < bus.op2_i)};
            EXE_OP_XOR:   alu_res_s = bus.op1_i ^ bus.op2_i;
            EXE_OP_OR:    alu_res_s = bus.op1_i | bus.op2_i;
            EXE_OP_AND:   alu_res_s = bus.op1_i & bus.op2_i;
            EXE_OP_PASS2: alu_res_s = bus.op2_i;
            EXE_OP_MUL:   alu_res_s = bus.op1_i * bus.op2_i;
            default: begin
                alu_res_s = XLEN_ZERO;
                alu_ok_s  = 1'b0;
            end
        endcase
    end

`ifdef RV32M_DIV_EN
    localparam logic DIV_EN = 1'b1;

    logic            div_start_s;
    logic            div_signed_s;
    logic [4:0]      lat_addr_r;
    logic            lat_we_r;
    logic            lat_rem_r;
    logic [XLEN-1:0] quot_s;
    logic [XLEN-1:0] remd_s;

    // Accept a divide only from idle and only if it is not being killed.
    always_comb begin
        div_start_s  = bus.inst_valid_i & is_div_op(bus.alu_op_i) & ~bus.flush_i
                     & ~div_busy_s & ~div_done_s;
        div_signed_s = (bus.alu_op_i == EXE_OP_DIV) | (bus.alu_op_i == EXE_OP_REM);
    end

    exe_div u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (div_start_s),
        .flush     (bus.flush_i),
        .is_signed (div_signed_s),
        .dividend  (bus.op1_i),
        .divisor   (bus.op2_i),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (quot_s),
        .remainder (remd_s)
    );

    // Capture destination info and result selection when a divide is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_addr_r <= 5'd0;
            lat_we_r   <= 1'b0;
            lat_rem_r  <= 1'b0;
        end else if (div_start_s) begin
            lat_addr_r <= bus.rd_addr_i;
            lat_we_r   <= bus.rd_we_i;
            lat_rem_r  <= (bus.alu_op_i == EXE_OP_REM) | (bus.alu_op_i == EXE_OP_REMU);
        end else begin
            lat_addr_r <= lat_addr_r;
            lat_we_r   <= lat_we_r;
            lat_rem_r  <= lat_rem_r;
        end
    end

    // Divider write-back view; writes to x0 are suppressed here.
    always_comb begin
        div_we_s   = lat_we_r & (lat_addr_r != 5'd0);
        div_addr_s = lat_addr_r;
        if (lat_rem_r) begin
            div_res_s = remd_s;
        end else begin
            div_res_s = quot_s;
        end
    end
`else
    localparam logic DIV_EN = 1'b0;

    // No divider: the divide path is permanently idle.
    always_comb begin
        div_busy_s = 1'b0;
        div_done_s = 1'b0;
        div_we_s   = 1'b0;
        div_addr_s = 5'd0;
        div_res_s  = XLEN_ZERO;
    end
`endif

    // Output selection; reset and flush override everything, and the
    // address/data are zero whenever no write is performed.
    always_comb begin
        rd_we_s   = 1'b0;
        rd_addr_s = 5'd0;
        rd_data_s = XLEN_ZERO;
        stall_s   = 1'b0;
        if (rst_i || bus.flush_i) begin
            rd_we_s = 1'b0;
        end else if (div_done_s) begin
            if (div_we_s) begin
                rd_we_s   = 1'b1;
                rd_addr_s = div_addr_s;
                rd_data_s = div_res_s;
            end else begin
                rd_we_s = 1'b0;
            end
        end else if (div_busy_s) begin
            stall_s = 1'b1;
        end else if (bus.inst_valid_i && is_div_op(bus.alu_op_i)) begin
            stall_s = DIV_EN;
        end else if (bus.inst_valid_i && bus.rd_we_i && (bus.rd_addr_i != 5'd0) && alu_ok_s) begin
            rd_we_s   = 1'b1;
            rd_addr_s = bus.rd_addr_i;
            rd_data_s = alu_res_s;
        end else begin
            rd_we_s = 1'b0;
        end
    end

    assign bus.rd_we_o   = rd_we_s;
    assign bus.rd_addr_o = rd_addr_s;
    assign bus.rd_data_o = rd_data_s;
    assign bus.stall_o   = stall_s;

endmodule
